rvfi_ref_tx: RTL and testbench

//  Transmit side of the RVFI lockstep link: buffers retirement records produced by the reference

---
 rtl/rvfi_ref_pkg.sv | 24 ++
 rtl/rvfi_ref_fifo.sv | 62 ++++++
 rtl/rvfi_ref_tx.sv | 140 ++++++++++++++
 tb/tb_rvfi_ref_tx.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_ref_pkg.sv
// Shared types for the RVFI reference-model transmit link.
// Record layout, FSM states and order-counter width.
package rvfi_ref_pkg;

    localparam int XLEN         = 32;
    localparam int ILEN         = 32;
    localparam int RVFI_ORDER_W = 64;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc_rdata;
        logic [XLEN-1:0] pc_wdata;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] rd_wdata;
        logic            trap;
        logic            halt;
    } rec_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/rvfi_ref_fifo.sv
// Synchronous record FIFO with flush; flush wins over push and pop.
// Occupancy is held explicitly so full/empty need no pointer tricks.
module rvfi_ref_fifo
    import rvfi_ref_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  rec_t          wdata_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output rec_t          head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rvfi_ref_tx.sv
// Reference-model retirement transmitter: buffers Spike records and
// emits one registered RVFI record per DUT retirement request.
module rvfi_ref_tx
    import rvfi_ref_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rec_valid_i,
    output logic                    rec_ready_o,
    input  rec_t                    rec_i,
    input  logic                    retire_req_i,
    input  logic                    flush_i,
    output logic                    rvfi_valid_o,
    output logic [RVFI_ORDER_W-1:0] rvfi_order_o,
    output logic [ILEN-1:0]         rvfi_insn_o,
    output logic [XLEN-1:0]         rvfi_pc_rdata_o,
    output logic [XLEN-1:0]         rvfi_pc_wdata_o,
    output logic [4:0]              rvfi_rd_addr_o,
    output logic [XLEN-1:0]         rvfi_rd_wdata_o,
    output logic                    rvfi_trap_o,
    output logic                    rvfi_halt_o,
    output logic                    underflow_o,
    output logic [CW-1:0]           count_o
);

    state_e                  state_q;
    state_e                  state_d;
    logic [RVFI_ORDER_W-1:0] order_q;
    logic [RVFI_ORDER_W-1:0] order_d;
    rec_t                    head;
    logic                    full;
    logic                    empty;
    logic                    push_en;
    logic                    pop_en;
    logic                    uf_set;

    logic                    valid_q;
    logic [RVFI_ORDER_W-1:0] ord_out_q;
    logic [ILEN-1:0]         insn_q;
    logic [XLEN-1:0]         pc_rdata_q;
    logic [XLEN-1:0]         pc_wdata_q;
    logic [4:0]              rd_addr_q;
    logic [XLEN-1:0]         rd_wdata_q;
    logic                    trap_q;
    logic                    halt_q;
    logic                    uf_q;

    rvfi_ref_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push_en),
        .wdata_i (rec_i),
        .pop_i   (pop_en),
        .flush_i (flush_i),
        .head_o  (head),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (pop_en && head.halt) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Ready looks only at current occupancy, never at a same-cycle pop.
    always_comb begin
        rec_ready_o = 1'b0;
        pop_en      = 1'b0;
        uf_set      = 1'b0;
        unique case (state_q)
            RUN: begin
                rec_ready_o = !full;
                pop_en      = retire_req_i && !empty && !flush_i;
                uf_set      = retire_req_i && empty;
            end
            default: ;
        endcase
    end

    assign push_en = rec_valid_i && rec_ready_o && !flush_i;
    assign order_d = pop_en ? order_q + RVFI_ORDER_W'(1) : order_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            order_q    <= '0;
            valid_q    <= 1'b0;
            ord_out_q  <= '0;
            insn_q     <= '0;
            pc_rdata_q <= '0;
            pc_wdata_q <= '0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
            trap_q     <= 1'b0;
            halt_q     <= 1'b0;
            uf_q       <= 1'b0;
        end else begin
            order_q <= order_d;
            valid_q <= pop_en;
            uf_q    <= uf_q | uf_set;
            if (pop_en) begin
                ord_out_q  <= order_q;
                insn_q     <= head.insn;
                pc_rdata_q <= head.pc_rdata;
                pc_wdata_q <= head.pc_wdata;
                rd_addr_q  <= head.rd_addr;
                rd_wdata_q <= (head.rd_addr == 5'd0) ? '0 : head.rd_wdata;
                trap_q     <= head.trap;
                halt_q     <= head.halt;
            end
        end
    end

    assign rvfi_valid_o    = valid_q;
    assign rvfi_order_o    = ord_out_q;
    assign rvfi_insn_o     = insn_q;
    assign rvfi_pc_rdata_o = pc_rdata_q;
    assign rvfi_pc_wdata_o = pc_wdata_q;
    assign rvfi_rd_addr_o  = rd_addr_q;
    assign rvfi_rd_wdata_o = rd_wdata_q;
    assign rvfi_trap_o     = trap_q;
    assign rvfi_halt_o     = halt_q;
    assign underflow_o     = uf_q;

endmodule

// File: tb/tb_rvfi_ref_tx.sv
// Directed bench for rvfi_ref_tx: ordering, full/empty edges,
// underflow, flush, rd zeroing, halt and mid-stream reset.
module tb_rvfi_ref_tx;
    import rvfi_ref_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rec_valid_i;
    logic        rec_ready_o;
    rec_t        rec_i;
    logic        retire_req_i;
    logic        flush_i;
    logic        rvfi_valid_o;
    logic [63:0] rvfi_order_o;
    logic [31:0] rvfi_insn_o;
    logic [31:0] rvfi_pc_rdata_o;
    logic [31:0] rvfi_pc_wdata_o;
    logic [4:0]  rvfi_rd_addr_o;
    logic [31:0] rvfi_rd_wdata_o;
    logic        rvfi_trap_o;
    logic        rvfi_halt_o;
    logic        underflow_o;
    logic [2:0]  count_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rvfi_ref_tx #(.DEPTH(4)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .rec_valid_i     (rec_valid_i),
        .rec_ready_o     (rec_ready_o),
        .rec_i           (rec_i),
        .retire_req_i    (retire_req_i),
        .flush_i         (flush_i),
        .rvfi_valid_o    (rvfi_valid_o),
        .rvfi_order_o    (rvfi_order_o),
        .rvfi_insn_o     (rvfi_insn_o),
        .rvfi_pc_rdata_o (rvfi_pc_rdata_o),
        .rvfi_pc_wdata_o (rvfi_pc_wdata_o),
        .rvfi_rd_addr_o  (rvfi_rd_addr_o),
        .rvfi_rd_wdata_o (rvfi_rd_wdata_o),
        .rvfi_trap_o     (rvfi_trap_o),
        .rvfi_halt_o     (rvfi_halt_o),
        .underflow_o     (underflow_o),
        .count_o         (count_o)
    );

    function automatic rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                input logic [31:0] wd, input logic trap,
                                input logic halt);
        rec_t r;
        r.insn     = {pc[15:0], 16'h0013};
        r.pc_rdata = pc;
        r.pc_wdata = pc + 32'd4;
        r.rd_addr  = rd;
        r.rd_wdata = wd;
        r.trap     = trap;
        r.halt     = halt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input rec_t r);
        rec_valid_i = 1'b1;
        rec_i       = r;
        tick();
        rec_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        n_chk++;
        if (rvfi_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", rvfi_valid_o);
        end
        n_chk++;
        if (count_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", count_o);
        end
        n_chk++;
        if (underflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_underflow: got %b want 0", underflow_o);
        end
        n_chk++;
        if (rvfi_order_o !== 64'd0 || rvfi_pc_rdata_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_data: got order %0d pc %h want 0 0",
                     rvfi_order_o, rvfi_pc_rdata_o);
        end
        rst_ni = 1'b1;
        tick();
        n_chk++;
        if (rec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", rec_ready_o);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) push(mk(32'h8000_0000 + 32'(4 * i), 5'd1, 32'(i), 1'b0, 1'b0));
        n_chk++;
        if (count_o !== 3'd3) begin
            n_err++;
            $display("FAIL basic_count: got %0d want 3", count_o);
        end
        retire_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (rvfi_valid_o !== 1'b1 || rvfi_order_o !== 64'(i) ||
                rvfi_pc_rdata_o !== 32'h8000_0000 + 32'(4 * i) ||
                rvfi_pc_wdata_o !== 32'h8000_0004 + 32'(4 * i)) begin
                n_err++;
                $display("FAIL basic_emit%0d: got v%b ord %0d pc %h npc %h want v1 ord %0d pc %h",
                         i, rvfi_valid_o, rvfi_order_o, rvfi_pc_rdata_o,
                         rvfi_pc_wdata_o, i, 32'h8000_0000 + 32'(4 * i));
            end
        end
        retire_req_i = 1'b0;
        tick();
        n_chk++;
        if (rvfi_valid_o !== 1'b0 || rvfi_pc_rdata_o !== 32'h8000_0008 ||
            count_o !== 3'd0) begin
            n_err++;
            $display("FAIL basic_hold: got v%b pc %h cnt %0d want v0 pc 80000008 cnt 0",
                     rvfi_valid_o, rvfi_pc_rdata_o, count_o);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [4];
        exp_pc = '{32'h104, 32'h108, 32'h10c, 32'h200};
        for (int i = 0; i < 4; i++) push(mk(32'h100 + 32'(4 * i), 5'd2, 32'h55, 1'b0, 1'b0));
        n_chk++;
        if (count_o !== 3'd4 || rec_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_state: got cnt %0d rdy %b want 4 0", count_o, rec_ready_o);
        end
        rec_valid_i  = 1'b1;
        rec_i        = mk(32'h200, 5'd2, 32'h66, 1'b0, 1'b0);
        retire_req_i = 1'b1;
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_pc_rdata_o !== 32'h100 ||
            rvfi_order_o !== 64'd3 || count_o !== 3'd3) begin
            n_err++;
            $display("FAIL full_popoffer: got v%b pc %h ord %0d cnt %0d want v1 100 3 3",
                     rvfi_valid_o, rvfi_pc_rdata_o, rvfi_order_o, count_o);
        end
        n_chk++;
        if (rec_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_ready_again: got %b want 1", rec_ready_o);
        end
        tick();
        rec_valid_i = 1'b0;
        n_chk++;
        if (count_o !== 3'd4) begin
            n_err++;
            $display("FAIL full_accept: got cnt %0d want 4", count_o);
        end
        retire_req_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (rvfi_valid_o !== 1'b1 || rvfi_pc_rdata_o !== exp_pc[i] ||
                rvfi_order_o !== 64'(4 + i)) begin
                n_err++;
                $display("FAIL full_drain%0d: got v%b pc %h ord %0d want v1 %h %0d",
                         i, rvfi_valid_o, rvfi_pc_rdata_o, rvfi_order_o,
                         exp_pc[i], 4 + i);
            end
        end
        retire_req_i = 1'b0;
        tick();
        n_chk++;
        if (underflow_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_uf: got %b want 0", underflow_o);
        end
    endtask

    task automatic test_underflow();
        retire_req_i = 1'b1;
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b0 || underflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL uf_set: got v%b uf %b want v0 uf1", rvfi_valid_o, underflow_o);
        end
        push(mk(32'h400, 5'd3, 32'h77, 1'b0, 1'b0));
        retire_req_i = 1'b1;
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_order_o !== 64'd8 || underflow_o !== 1'b1) begin
            n_err++;
            $display("FAIL uf_sticky: got v%b ord %0d uf %b want v1 8 1",
                     rvfi_valid_o, rvfi_order_o, underflow_o);
        end
        tick();
    endtask

    task automatic test_flush();
        push(mk(32'h500, 5'd4, 32'h1, 1'b0, 1'b0));
        push(mk(32'h504, 5'd4, 32'h2, 1'b0, 1'b0));
        flush_i      = 1'b1;
        retire_req_i = 1'b1;
        tick();
        flush_i      = 1'b0;
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b0 || count_o !== 3'd0) begin
            n_err++;
            $display("FAIL flush_drop: got v%b cnt %0d want v0 0", rvfi_valid_o, count_o);
        end
        push(mk(32'h508, 5'd4, 32'h3, 1'b0, 1'b0));
        retire_req_i = 1'b1;
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_order_o !== 64'd9 ||
            rvfi_pc_rdata_o !== 32'h508) begin
            n_err++;
            $display("FAIL flush_order: got v%b ord %0d pc %h want v1 9 508",
                     rvfi_valid_o, rvfi_order_o, rvfi_pc_rdata_o);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        push(mk(32'h600, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0));
        push(mk(32'h604, 5'd5, 32'h0000_1234, 1'b1, 1'b0));
        retire_req_i = 1'b1;
        tick();
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_rd_wdata_o !== 32'd0 ||
            rvfi_rd_addr_o !== 5'd0 || rvfi_order_o !== 64'd10) begin
            n_err++;
            $display("FAIL rd0_zero: got v%b rd %0d wd %h ord %0d want v1 0 0 10",
                     rvfi_valid_o, rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_order_o);
        end
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_rd_wdata_o !== 32'h1234 || rvfi_rd_addr_o !== 5'd5 ||
            rvfi_trap_o !== 1'b1 || rvfi_insn_o !== 32'h0604_0013) begin
            n_err++;
            $display("FAIL rd5_pass: got rd %0d wd %h trap %b insn %h want 5 1234 1 06040013",
                     rvfi_rd_addr_o, rvfi_rd_wdata_o, rvfi_trap_o, rvfi_insn_o);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        push(mk(32'h700, 5'd6, 32'h9, 1'b0, 1'b0));
        push(mk(32'h704, 5'd6, 32'hA, 1'b0, 1'b0));
        retire_req_i = 1'b1;
        rst_ni       = 1'b0;
        tick();
        rst_ni       = 1'b1;
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b0 || count_o !== 3'd0 || underflow_o !== 1'b0 ||
            rvfi_order_o !== 64'd0 || rvfi_pc_rdata_o !== 32'd0) begin
            n_err++;
            $display("FAIL rst_mid: got v%b cnt %0d uf %b ord %0d pc %h want all 0",
                     rvfi_valid_o, count_o, underflow_o, rvfi_order_o, rvfi_pc_rdata_o);
        end
        tick();
        n_chk++;
        if (rvfi_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: got %b want 0", rvfi_valid_o);
        end
        push(mk(32'h710, 5'd7, 32'hB, 1'b0, 1'b0));
        retire_req_i = 1'b1;
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_order_o !== 64'd0 ||
            rvfi_pc_rdata_o !== 32'h710) begin
            n_err++;
            $display("FAIL rst_mid_restart: got v%b ord %0d pc %h want v1 0 710",
                     rvfi_valid_o, rvfi_order_o, rvfi_pc_rdata_o);
        end
        tick();
    endtask

    task automatic test_halt();
        push(mk(32'h800, 5'd8, 32'hC, 1'b0, 1'b1));
        retire_req_i = 1'b1;
        tick();
        n_chk++;
        if (rvfi_valid_o !== 1'b1 || rvfi_halt_o !== 1'b1 || rvfi_order_o !== 64'd1) begin
            n_err++;
            $display("FAIL halt_emit: got v%b halt %b ord %0d want v1 1 1",
                     rvfi_valid_o, rvfi_halt_o, rvfi_order_o);
        end
        n_chk++;
        if (rec_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL halt_ready: got %b want 0", rec_ready_o);
        end
        tick();
        retire_req_i = 1'b0;
        n_chk++;
        if (rvfi_valid_o !== 1'b0 || underflow_o !== 1'b0 || rvfi_halt_o !== 1'b1) begin
            n_err++;
            $display("FAIL halt_ignore: got v%b uf %b halt %b want v0 uf0 halt1",
                     rvfi_valid_o, underflow_o, rvfi_halt_o);
        end
        rec_valid_i = 1'b1;
        rec_i       = mk(32'h804, 5'd8, 32'hD, 1'b0, 1'b0);
        tick();
        rec_valid_i = 1'b0;
        n_chk++;
        if (count_o !== 3'd0) begin
            n_err++;
            $display("FAIL halt_nopush: got cnt %0d want 0", count_o);
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        rec_valid_i  = 1'b0;
        rec_i        = '0;
        retire_req_i = 1'b0;
        flush_i      = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_underflow();
        test_flush();
        test_rd_zero();
        test_reset_midstream();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
